// File: rtl/vector_pkg.sv
// vector_pkg: display-list word layout, opcodes and reader FSM states shared by the vector front end.
package vector_pkg;
  localparam int COORD_W = 12;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;
  localparam int Y_MSB = 23;
  localparam int Y_LSB = 12;
  localparam int X_MSB = 11;
  localparam int X_LSB = 0;
  typedef enum logic [1:0] {
    OP_JUMP = 2'b00,
    OP_DRAW = 2'b01,
    OP_END  = 2'b10,
    OP_NOP  = 2'b11
  } opcode_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HOLD} state_t;
endpackage

// File: rtl/dl_word_decode.sv
// dl_word_decode: splits a 32-bit display-list word into opcode and x/y coordinates.
module dl_word_decode
  import vector_pkg::*;
(
  input  logic [31:0]        word,
  output opcode_t            op,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               is_cmd
);
  logic unused_rsvd;
  assign op          = opcode_t'(word[OP_MSB:OP_LSB]);
  assign y           = word[Y_MSB:Y_LSB];
  assign x           = word[X_MSB:X_LSB];
  assign is_cmd      = (op == OP_JUMP) || (op == OP_DRAW);
  assign unused_rsvd = ^word[29:24];
endmodule

// File: rtl/display_list_reader.sv
// display_list_reader: walks a display list in RAM and issues jump/draw commands to the vector control block.
// Define AUTO_REFRESH_EN to loop back to the list base on END instead of returning to IDLE.
module display_list_reader
  import vector_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  list_base,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [31:0]        mem_data,
  input  logic               ctl_ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  output logic               busy,
  output logic               frame_done,
  output logic               err_overrun
);
  localparam int HOLD_W = 8;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
  logic [1:0]          lat_q, lat_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         word_q, word_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                err_q, err_d, stop_q, stop_d;
  opcode_t             op;
  logic [COORD_W-1:0]  wx, wy;
  logic                is_cmd, issue, wrapped;

  dl_word_decode u_dec (.word(word_q), .op(op), .x(wx), .y(wy), .is_cmd(is_cmd));

  assign issue       = (state_q == ISSUE) && is_cmd && ctl_ready;
  // Reaching the base again on a fetch means the whole RAM was walked with no END.
  assign wrapped     = addr_q == base_q;
  assign mem_rd      = state_q == FETCH;
  assign mem_addr    = addr_q;
  assign busy        = state_q != IDLE;
  assign jump        = issue && (op == OP_JUMP);
  assign draw        = issue && (op == OP_DRAW);
  assign frame_done  = (state_q == ISSUE) && (op == OP_END) && !stop;
  assign err_overrun = err_q;
  assign x           = x_d;
  assign y           = y_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    word_d  = word_q;
    err_d   = err_q;
    stop_d  = stop_q;
    x_d     = issue ? wx : x_q;
    y_d     = issue ? wy : y_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        addr_d  = list_base;
        base_d  = list_base;
        err_d   = 1'b0;
        stop_d  = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        addr_d  = addr_q + ADDR_W'(1);
        lat_d   = '0;
        state_d = stop ? IDLE : WAIT;
      end
      WAIT: if (stop) begin
        state_d = IDLE;
      end else if (lat_q == 2'(MEM_LAT - 1)) begin
        word_d  = mem_data;
        state_d = ISSUE;
      end else begin
        lat_d = lat_q + 2'd1;
      end
      ISSUE: if (issue) begin
        hold_d  = HOLD_W'(HOLDOFF);
        state_d = stop ? IDLE : HOLD;
      end else if (stop) begin
        state_d = IDLE;
      end else if (op == OP_END) begin
`ifdef AUTO_REFRESH_EN
        addr_d  = base_q;
        state_d = FETCH;
`else
        state_d = IDLE;
`endif
      end else if (op == OP_NOP) begin
        err_d   = err_q | wrapped;
        state_d = wrapped ? IDLE : FETCH;
      end
      HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        stop_d = stop_q | stop;
        if (hold_q <= HOLD_W'(1)) begin
          err_d   = err_q | (wrapped && !(stop_q || stop));
          state_d = (stop_q || stop || wrapped) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      lat_q   <= '0;
      hold_q  <= '0;
      word_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end
endmodule
